// File: rtl/dir_det_pkg.sv
// Shared definitions for the direction-detector frame sequencer.
//   state_e   : sequencer FSM states
//   DIR_W     : width of a detector direction code
//   SAMPLE_W  : width of a signed detector sample
//   DIR_NONE  : direction reported when a frame ends by timeout
package dir_det_pkg;

  localparam int DIR_W    = 3;
  localparam int SAMPLE_W = 8;

  localparam logic [DIR_W-1:0] DIR_NONE = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HOLD  = 3'd4
  } state_e;

endpackage

// File: rtl/dir_det_frame_cnt.sv
// Per-frame sample and detector-valid counters with compare-to-length.
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_clr          : synchronous clear of both counters
//   i_len          : latched frame length L (non-zero)
//   i_sample_inc   : a sample is being accepted this cycle
//   i_valid_inc    : a detector valid is being counted this cycle
//   o_last_sample  : this cycle's accept is the L-th sample
//   o_last_valid   : this cycle's valid is the L-th valid
module dir_det_frame_cnt #(
  parameter int LEN_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic [LEN_W-1:0] i_len,
  input  logic             i_sample_inc,
  input  logic             i_valid_inc,
  output logic             o_last_sample,
  output logic             o_last_valid
);

  logic [LEN_W-1:0] r_s_cnt;
  logic [LEN_W-1:0] r_v_cnt;
  logic [LEN_W:0]   w_s_next;
  logic [LEN_W:0]   w_v_next;

  // One spare bit so L = 2^LEN_W-1 compares without wrap.
  assign w_s_next = {1'b0, r_s_cnt} + (LEN_W+1)'(1);
  assign w_v_next = {1'b0, r_v_cnt} + (LEN_W+1)'(1);

  assign o_last_sample = i_sample_inc && (w_s_next == {1'b0, i_len});
  assign o_last_valid  = i_valid_inc  && (w_v_next == {1'b0, i_len});

  // Counters saturate at L so extra events never wrap back into range.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_clr) begin
      r_s_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      if (i_sample_inc && (r_s_cnt != i_len)) r_s_cnt <= w_s_next[LEN_W-1:0];
      if (i_valid_inc  && (r_v_cnt != i_len)) r_v_cnt <= w_v_next[LEN_W-1:0];
    end
  end

endmodule

// File: rtl/dir_det_sequencer.sv
// Frame-level controller in front of the direction detector.
// Per frame: one CLEAR cycle resets the detector, exactly L source samples
// are forwarded (registered, latency 1), then the L-th detector valid's
// direction (or a timeout) is offered on the result port.
//   i_start/i_frame_len : start a frame of L samples (IDLE only, L != 0)
//   i_abort             : drop the current frame, no result
//   i_s_valid/i_s_data/o_s_ready       : sample source
//   o_det_rst/o_det_enb/o_det_data     : detector drive
//   i_det_dir/i_det_valid              : detector result
//   o_r_valid/o_r_dir/o_r_timeout/i_r_ready : frame result
//   o_busy      : any state other than IDLE
//   o_dbg_state : current FSM state (dir_det_pkg::state_e encoding)
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high; a valid side holds its payload stable until then.
module dir_det_sequencer
  import dir_det_pkg::*;
#(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = 5
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_frame_len,
  input  logic             i_abort,
  input  logic             i_s_valid,
  input  logic [7:0]       i_s_data,
  output logic             o_s_ready,
  output logic             o_det_rst,
  output logic             o_det_enb,
  output logic [7:0]       o_det_data,
  input  logic [2:0]       i_det_dir,
  input  logic             i_det_valid,
  output logic             o_r_valid,
  output logic [2:0]       o_r_dir,
  output logic             o_r_timeout,
  input  logic             i_r_ready,
  output logic             o_busy,
  output logic [2:0]       o_dbg_state
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e              r_state;
  logic [LEN_W-1:0]    r_len;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_s_ready;
  logic                r_det_rst;
  logic                r_det_enb;
  logic [SAMPLE_W-1:0] r_det_data;
  logic                r_r_valid;
  logic [DIR_W-1:0]    r_r_dir;
  logic                r_r_timeout;

  logic w_accept;
  logic w_valid_inc;
  logic w_last_sample;
  logic w_last_valid;

  assign w_accept    = i_s_valid & r_s_ready;
  assign w_valid_inc = i_det_valid & ((r_state == ST_FEED) | (r_state == ST_WAIT));

  dir_det_frame_cnt #(.LEN_W(LEN_W)) u_frame_cnt (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clr         (r_state == ST_CLEAR),
    .i_len         (r_len),
    .i_sample_inc  (w_accept),
    .i_valid_inc   (w_valid_inc),
    .o_last_sample (w_last_sample),
    .o_last_valid  (w_last_valid)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_len       <= '0;
      r_to_cnt    <= '0;
      r_s_ready   <= 1'b0;
      r_det_rst   <= 1'b0;
      r_det_enb   <= 1'b0;
      r_det_data  <= '0;
      r_r_valid   <= 1'b0;
      r_r_dir     <= '0;
      r_r_timeout <= 1'b0;
    end else begin
      r_det_rst <= 1'b0;
      r_det_enb <= w_accept & ~i_abort;
      if (w_accept) r_det_data <= i_s_data;

      if (i_abort && (r_state != ST_IDLE)) begin
        r_state   <= ST_IDLE;
        r_s_ready <= 1'b0;
        r_r_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start && (i_frame_len != '0)) begin
              r_len     <= i_frame_len;
              r_det_rst <= 1'b1;       // high exactly while in CLEAR
              r_state   <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            r_s_ready <= 1'b1;
            r_state   <= ST_FEED;
          end
          ST_FEED: begin
            // The L-th detector valid can only precede the L-th sample if
            // the detector runs ahead; it still closes the frame.
            if (w_last_valid) begin
              r_r_dir     <= i_det_dir;
              r_r_timeout <= 1'b0;
              r_r_valid   <= 1'b1;
              r_s_ready   <= 1'b0;
              r_state     <= ST_HOLD;
            end else if (w_last_sample) begin
              r_s_ready <= 1'b0;
              r_to_cnt  <= '0;
              r_state   <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
            // Final valid is checked first so it wins a same-cycle timeout.
            if (w_last_valid) begin
              r_r_dir     <= i_det_dir;
              r_r_timeout <= 1'b0;
              r_r_valid   <= 1'b1;
              r_state     <= ST_HOLD;
            end else if (r_to_cnt == TO_LAST) begin
              r_r_dir     <= DIR_NONE;
              r_r_timeout <= 1'b1;
              r_r_valid   <= 1'b1;
              r_state     <= ST_HOLD;
            end
          end
          ST_HOLD: begin
            if (i_r_ready) begin
              r_r_valid <= 1'b0;
              r_state   <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign o_s_ready   = r_s_ready;
  assign o_det_rst   = r_det_rst;
  assign o_det_enb   = r_det_enb;
  assign o_det_data  = r_det_data;
  assign o_r_valid   = r_r_valid;
  assign o_r_dir     = r_r_dir;
  assign o_r_timeout = r_r_timeout;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_dir_det_sequencer.sv
module tb_dir_det_sequencer;
  import dir_det_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic i_rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       i_start, i_abort, i_s_valid, i_r_ready;
  logic [7:0] i_frame_len, i_s_data;
  logic       o_s_ready, o_det_rst, o_det_enb, o_r_valid, o_r_timeout, o_busy;
  logic [7:0] o_det_data;
  logic [2:0] o_r_dir, o_dbg_state;
  logic [2:0] i_det_dir;
  logic       i_det_valid;

  dir_det_sequencer #(.LEN_W(8), .TIMEOUT(16), .TO_W(5)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_frame_len (i_frame_len),
    .i_abort     (i_abort),
    .i_s_valid   (i_s_valid),
    .i_s_data    (i_s_data),
    .o_s_ready   (o_s_ready),
    .o_det_rst   (o_det_rst),
    .o_det_enb   (o_det_enb),
    .o_det_data  (o_det_data),
    .i_det_dir   (i_det_dir),
    .i_det_valid (i_det_valid),
    .o_r_valid   (o_r_valid),
    .o_r_dir     (o_r_dir),
    .o_r_timeout (o_r_timeout),
    .i_r_ready   (i_r_ready),
    .o_busy      (o_busy),
    .o_dbg_state (o_dbg_state)
  );

  // ---------------- detector model: valid 2 cycles after each enb ----------------
  logic       det_on, force_valid;
  logic [2:0] det_dir;
  logic       p0, p1;
  always @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      p0 <= 1'b0;
      p1 <= 1'b0;
    end else begin
      p0 <= o_det_enb & det_on;
      p1 <= p0;
    end
  end
  assign i_det_valid = p1 | force_valid;
  assign i_det_dir   = det_dir;

  // ---------------- counters and checker ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard: sample order and enb latency ----------------
  logic [7:0] exp_q[$];
  logic       mon_on   = 1'b0;
  logic       prev_acc = 1'b0;
  int         rst_cnt, enb_cnt, wait_cnt;

  always @(negedge clk) begin
    if (mon_on) begin
      check("enb_latency", o_det_enb, prev_acc);
      if (o_det_enb) begin
        enb_cnt++;
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("det_data", o_det_data, exp_q.pop_front());
      end
      if (i_s_valid && o_s_ready) exp_q.push_back(i_s_data);
      prev_acc = i_s_valid && o_s_ready;
      if (o_det_rst) rst_cnt++;
      if (o_dbg_state == ST_WAIT) wait_cnt++;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          len;
    bit          gap;
    bit          det_on;
    logic [2:0]  dir;
    logic [2:0]  exp_dir;
    bit          exp_to;
    int          exp_wait;
    logic [31:0] d;       // first four samples, MSB byte first
  } vec_t;

  vec_t vecs[6];
  logic [7:0] sdat[256];

  function automatic vec_t mk(int len, bit gap, bit on, logic [2:0] dir,
                              logic [2:0] edir, bit eto, int ew, logic [31:0] d);
    vec_t v;
    v.len = len; v.gap = gap; v.det_on = on; v.dir = dir;
    v.exp_dir = edir; v.exp_to = eto; v.exp_wait = ew; v.d = d;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_samples(input vec_t v);
    for (int k = 0; k < 256; k++)
      sdat[k] = (k < 4) ? v.d[31-8*k -: 8] : 8'(k*37 + 5);
  endtask

  task automatic start_frame(input int len);
    i_frame_len = 8'(len);
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
    check("busy_after_start", o_busy, 1);
  endtask

  // Offers samples until n are accepted; keeps a stray start asserted meanwhile.
  task automatic feed(input int n, input bit gap);
    int k = 0;
    int cyc = 0;
    logic acc;
    i_start     = 1'b1;
    i_frame_len = 8'd7;
    while (k < n && cyc < 2000) begin
      i_s_valid = gap ? (cyc % 2 == 0) : 1'b1;
      i_s_data  = sdat[k];
      @(negedge clk);
      acc = i_s_valid && o_s_ready;
      tick();
      if (acc) k++;
      cyc++;
    end
    i_start   = 1'b0;
    i_s_valid = 1'b0;
    check("feed_count", k, n);
  endtask

  task automatic wait_result();
    int n = 0;
    while (!o_r_valid && n < 100) begin
      tick();
      n++;
    end
    check("r_valid_rise", o_r_valid, 1);
  endtask

  task automatic finish_result(input logic [2:0] dir, input bit to);
    repeat (2) tick();
    check("r_hold", {o_r_valid, o_r_dir, o_r_timeout}, {1'b1, dir, to});
    i_r_ready   = 1'b1;
    i_start     = 1'b1;
    i_frame_len = 8'd3;
    tick();
    i_r_ready = 1'b0;
    i_start   = 1'b0;
    check("r_drop", o_r_valid, 0);
    tick();
    check("idle_after_hs", o_busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    det_on  = v.det_on;
    det_dir = v.dir;
    load_samples(v);
    rst_cnt = 0; enb_cnt = 0; wait_cnt = 0;
    start_frame(v.len);
    feed(v.len, v.gap);
    // Source keeps offering after the last sample; nothing more may be taken.
    i_s_valid = 1'b1;
    i_s_data  = 8'h55;
    repeat (2) begin
      @(negedge clk);
      check("ready_low_after_last", o_s_ready, 0);
    end
    i_s_valid = 1'b0;
    tick();
    wait_result();
    check("r_dir", o_r_dir, v.exp_dir);
    check("r_timeout", o_r_timeout, v.exp_to);
    check("clear_cycles", rst_cnt, 1);
    check("enb_count", enb_cnt, v.len);
    check("wait_cycles", wait_cnt, v.exp_wait);
    finish_result(v.exp_dir, v.exp_to);
  endtask

  // ---------------- test ----------------
  initial begin
    i_rst = 1'b1;
    i_start = 0; i_abort = 0; i_s_valid = 0; i_r_ready = 0;
    i_frame_len = 0; i_s_data = 0;
    det_on = 0; force_valid = 0; det_dir = 0;

    vecs[0] = mk(4,   0, 1, 3'd5, 3'd5, 0, 3,  32'h0AFD0702);
    vecs[1] = mk(3,   1, 1, 3'd3, 3'd3, 0, 3,  32'h81C07F01);
    vecs[2] = mk(2,   0, 0, 3'd7, 3'd0, 1, 16, 32'h12345678);
    vecs[3] = mk(1,   0, 1, 3'd6, 3'd6, 0, 3,  32'h80000000);
    vecs[4] = mk(255, 0, 1, 3'd2, 3'd2, 0, 3,  32'hA5A5A5A5);
    vecs[5] = mk(5,   1, 1, 3'd1, 3'd1, 0, 3,  32'hFF00FF00);

    #12;
    check("reset_outputs",
          {o_s_ready, o_det_rst, o_det_enb, o_det_data, o_r_valid, o_r_dir, o_r_timeout, o_busy}, 0);
    tick();
    i_rst  = 1'b0;
    mon_on = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Zero-length start is ignored.
    rst_cnt = 0;
    i_frame_len = 8'd0;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    check("len0_busy", o_busy, 0);
    tick();
    check("len0_no_clear", rst_cnt, 0);

    // Abort after 1 of 4 samples, then a clean frame.
    det_on = 1; det_dir = 3'd4;
    load_samples(mk(4, 0, 1, 3'd4, 3'd4, 0, 3, 32'h01020304));
    start_frame(4);
    feed(1, 0);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check("abort_state", {o_busy, o_s_ready, o_det_enb, o_r_valid}, 0);
    begin
      logic seen = 1'b0;
      repeat (6) begin
        tick();
        seen |= o_r_valid | o_busy;
      end
      check("abort_no_result", seen, 0);
    end
    run_vec(mk(3, 0, 1, 3'd4, 3'd4, 0, 3, 32'h11223344));

    // Final valid in the same cycle the timeout expires: valid wins.
    det_on = 0; det_dir = 3'd3;
    load_samples(mk(1, 0, 0, 3'd3, 3'd3, 0, 0, 32'h33000000));
    start_frame(1);
    feed(1, 0);
    check("sc_in_wait", o_dbg_state, ST_WAIT);
    repeat (15) tick();
    check("sc_still_wait", o_dbg_state, ST_WAIT);
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    check("sc_r_valid", o_r_valid, 1);
    check("sc_timeout", o_r_timeout, 0);
    finish_result(3'd3, 0);

    // Asynchronous reset mid-WAIT clears every output before the next edge.
    det_on = 0;
    load_samples(mk(2, 0, 0, 3'd0, 3'd0, 1, 16, 32'h21420000));
    start_frame(2);
    feed(2, 0);
    repeat (4) tick();
    check("pre_rst_wait", o_dbg_state, ST_WAIT);
    mon_on = 1'b0;
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_outputs",
          {o_s_ready, o_det_rst, o_det_enb, o_det_data, o_r_valid, o_r_dir, o_r_timeout, o_busy}, 0);
    tick();
    i_rst = 1'b0;
    exp_q.delete();
    prev_acc = 1'b0;
    tick();
    check("post_rst_idle", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dir_det_sequencer.md
Name: dir_det_sequencer

Overview:
Frame-level controller that sequences the 8-bit signed sample stream into the direction detector (i_enb/i_data in, o_dir/o_valid out).
- Per frame: clears the detector, feeds exactly N samples from an upstream valid/ready source, then waits for the N-th detector valid.
- Returns that 3-bit direction as one frame result, or a timeout flag, on a valid/ready result port.
- Sits between the sample source / host control and the detector instance.

Parameters:
LEN_W, 8, width of frame length and of the valid counter
TIMEOUT, 16, max cycles allowed in WAIT without the final detector valid
TO_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_start  in  1  start-frame pulse, sampled only in IDLE
i_frame_len  in  LEN_W  samples per frame, latched on accepted start
i_abort  in  1  abandon the current frame, any state
i_s_valid  in  1  source sample valid
i_s_data  in  8  source sample, signed
o_s_ready  out  1  sequencer accepts a sample
o_det_rst  out  1  synchronous clear to the detector
o_det_enb  out  1  detector enable, registered
o_det_data  out  8  detector sample, registered
i_det_dir  in  3  detector direction
i_det_valid  in  1  detector result valid
o_r_valid  out  1  frame result valid
o_r_dir  out  3  frame direction
o_r_timeout  out  1  result produced by timeout
i_r_ready  in  1  result consumer ready
o_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, i_rst=1): state IDLE. All outputs 0, all counters 0.
- States: IDLE, CLEAR, FEED, WAIT, HOLD.
- IDLE:
  - i_start=1 with i_frame_len!=0: latch length L, go to CLEAR.
  - i_start with i_frame_len=0: ignored, stays IDLE.
- CLEAR: exactly 1 cycle. o_det_rst=1, sample and valid counters cleared, then FEED.
- FEED:
  - o_s_ready=1.
  - A sample is accepted when i_s_valid & o_s_ready. It is registered to o_det_data with o_det_enb=1 in the next cycle (latency 1); otherwise o_det_enb=0 next cycle.
  - On accepting the L-th sample, o_s_ready drops the same edge and the state goes to WAIT.
- Valid counting: during FEED and WAIT, each i_det_valid=1 increments the valid count.
  - The valid that makes the count equal L captures i_det_dir into o_r_dir, sets o_r_timeout=0 and moves to HOLD. This may happen in FEED or in WAIT.
  - Valids beyond L are ignored.
- WAIT:
  - o_s_ready=0. The timeout counter starts at 0 on entry and increments every cycle.
  - If the L-th valid has not arrived when the counter reaches TIMEOUT, go to HOLD with o_r_dir=3'b000 and o_r_timeout=1.
  - If the L-th valid and the timeout hit occur in the same cycle, the valid wins.
- HOLD: o_r_valid=1 with o_r_dir and o_r_timeout stable until i_r_ready=1, then IDLE. An i_start in the handshake cycle is ignored.
- i_abort=1 in any non-IDLE state:
  - Next state IDLE, no result produced.
  - o_s_ready=0 and o_det_enb=0 from the next cycle.
  - o_r_valid drops if it was in HOLD.
  - Abort has priority over every other transition.
- o_det_rst is only asserted in CLEAR. Global reset of the detector remains i_rst.
- Counters are LEN_W bits. L=2^LEN_W-1 must work without wrap.

Decomposition:
- Shared package dir_det_pkg holds:
  - state enum typedef (IDLE, CLEAR, FEED, WAIT, HOLD)
  - DIR_W=3 and SAMPLE_W=8 constants
  - DIR_NONE=3'b000 constant
- One sub-module is natural: dir_det_frame_cnt, holding the sample counter, valid counter and compare-to-L logic. FSM and registered datapath stay in the top.

Test Plan:
- L=4, samples 10,-3,7,2 back-to-back, detector model returns a valid 2 cycles after each enb, 4th dir=3'b101 -> CLEAR pulse 1 cycle; o_det_enb high 4 cycles starting 1 cycle after each accept; o_r_valid=1, o_r_dir=5, o_r_timeout=0; held until i_r_ready.
- L=3, i_s_valid toggles 1/0 -> exactly 3 accepts; o_s_ready=0 after the 3rd; data order preserved on o_det_data.
- L=2, detector never asserts valid -> WAIT lasts TIMEOUT=16 cycles; o_r_valid=1, o_r_dir=0, o_r_timeout=1.
- Final valid in the same cycle as timeout expiry -> o_r_timeout=0, captured dir is output.
- i_abort mid-FEED after 1 of 4 samples -> IDLE next cycle, o_busy=0, no o_r_valid; a new i_start then runs a clean frame including CLEAR.
- i_start with i_frame_len=0 -> stays IDLE. i_start during FEED -> ignored. i_rst asserted mid-WAIT -> all outputs 0 immediately (async).
